// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding, frame geometry and a helper for
// stepping the round-robin pointer.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  localparam int unsigned UART_FRAME_BITS     = 10;
  localparam int unsigned UART_DIV_50M_115200 = 434;

  // Next requester index after i, wrapping at n.
  function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Per-requester byte-stream handshake bundle shared by all UART TX sources.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   io_req_valid;
  logic [NUM_REQ*8-1:0] io_req_bits;
  logic [NUM_REQ-1:0]   io_req_last;
  logic [NUM_REQ-1:0]   io_req_ready;

  modport master (
    output io_req_valid,
    output io_req_bits,
    output io_req_last,
    input  io_req_ready
  );

  modport slave (
    input  io_req_valid,
    input  io_req_bits,
    input  io_req_last,
    output io_req_ready
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// One-entry holding register feeding an 8N1 serializer with a fixed baud divisor.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DIVISOR = UART_DIV_50M_115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       hold_empty,
  output logic       txd,
  output logic       busy
);

  localparam int unsigned CntW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(DIVISOR - 1);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic            load;

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;

    if (wr_en) begin
      hold_d      = wr_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_q == '0) begin
          state_d = StData;
          baud_d  = BaudLast;
          idx_d   = '0;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StData: begin
        if (baud_q == '0) begin
          baud_d = BaudLast;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StStop: begin
        if (baud_q == '0) begin
          // A waiting byte starts immediately so consecutive frames have no idle gap.
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      baud_d      = BaudLast;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      baud_q      <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // Decoded from state so an asynchronous reset drives the line high at once.
  always_comb begin
    txd = 1'b1;
    if (state_q == StStart) begin
      txd = 1'b0;
    end else if (state_q == StData) begin
      txd = shift_q[0];
    end
  end

  assign hold_empty = ~hold_full_q;
  assign busy       = hold_full_q | (state_q != StIdle);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with per-message grant lock and idle timeout in front of a shared
// UART TX serializer.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned DIVISOR      = UART_DIV_50M_115200,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic                       clock,
  input  logic                       reset,
  uart_tx_arbiter_if.slave           req,
  output logic                       io_txd,
  output logic                       io_busy,
  output logic [$clog2(NUM_REQ)-1:0] io_grant_id
);

  localparam int unsigned IdW = $clog2(NUM_REQ);
  localparam int unsigned TW  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TimeoutLast = TW'(LOCK_TIMEOUT - 1);

  logic           lock_q, lock_d;
  logic [IdW-1:0] owner_q, owner_d;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] gid_q, gid_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;

  logic [IdW-1:0]     winner, sel;
  logic               found, xfer, xfer_last;
  logic [7:0]         xfer_data;
  logic [NUM_REQ-1:0] ready;
  logic               hold_empty;
  int                 cand;

  // Search for the first valid requester starting at the pointer.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand = int'(32'(ptr_q)) + k;
      if (cand >= int'(NUM_REQ)) cand = cand - int'(NUM_REQ);
      if (!found && req.io_req_valid[cand]) begin
        found  = 1'b1;
        winner = IdW'(cand);
      end
    end
  end

  always_comb begin
    sel   = lock_q ? owner_q : winner;
    ready = '0;
    if ((lock_q || found) && hold_empty && reset) begin
      ready[sel] = 1'b1;
    end
  end

  assign req.io_req_ready = ready;
  assign xfer             = |(ready & req.io_req_valid);
  assign xfer_data        = req.io_req_bits[int'(sel)*8 +: 8];
  assign xfer_last        = req.io_req_last[sel];

  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    tcnt_d  = tcnt_q;
    if (xfer) begin
      gid_d  = sel;
      tcnt_d = '0;
      if (xfer_last) begin
        lock_d = 1'b0;
        ptr_d  = IdW'(wrap_inc(32'(sel), NUM_REQ));
      end else begin
        lock_d  = 1'b1;
        owner_d = sel;
      end
    end else if (lock_q && (LOCK_TIMEOUT != 0) && !req.io_req_valid[owner_q]) begin
      if (tcnt_q == TimeoutLast) begin
        lock_d = 1'b0;
        ptr_d  = IdW'(wrap_inc(32'(owner_q), NUM_REQ));
        tcnt_d = '0;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      gid_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign io_grant_id = gid_q;

  uart_tx_serializer #(
    .DIVISOR(DIVISOR)
  ) u_serializer (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (xfer),
    .wr_data   (xfer_data),
    .hold_empty(hold_empty),
    .txd       (io_txd),
    .busy      (io_busy)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: decodes frames off io_txd and checks ordering,
// latency, frame length, lock/timeout behaviour and asynchronous reset.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int DIV   = 16;
  localparam int TO    = 100;
  localparam int FRAME = 10 * DIV;

  logic       clock;
  logic       reset;
  logic       v0, v1, l0, l1;
  logic [7:0] b0, b1;
  logic       io_txd, io_busy;
  logic [0:0] io_grant_id;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  uart_tx_arbiter_if #(.NUM_REQ(2)) bus ();

  assign bus.io_req_valid = {v1, v0};
  assign bus.io_req_bits  = {b1, b0};
  assign bus.io_req_last  = {l1, l0};

  uart_tx_arbiter #(
    .NUM_REQ     (2),
    .DIVISOR     (DIV),
    .LOCK_TIMEOUT(TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (bus.slave),
    .io_txd     (io_txd),
    .io_busy    (io_busy),
    .io_grant_id(io_grant_id)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge following the accepting edge.
  task automatic push(input int i, input logic [7:0] b, input logic l, output int acc);
    bit done = 0;
    if (i == 0) begin v0 = 1'b1; b0 = b; l0 = l; end
    else begin v1 = 1'b1; b1 = b; l1 = l; end
    #1;
    acc = -1;
    for (int n = 0; n < 40 * DIV; n++) begin
      if (bus.io_req_ready[i] === 1'b1) begin
        @(posedge clock);
        #1;
        acc  = cyc;
        done = 1;
        @(negedge clock);
        break;
      end
      @(negedge clock);
      #1;
    end
    if (!done) check("push_timeout", 32'(0), 32'(1));
  endtask

  task automatic rx(output logic [7:0] b, output int fall);
    bit seen = 0;
    b    = '0;
    fall = -1;
    for (int n = 0; n < 30 * DIV; n++) begin
      @(negedge clock);
      if (io_txd === 1'b0) begin
        seen = 1;
        fall = cyc;
        break;
      end
    end
    if (!seen) begin
      check("rx_timeout", 32'(0), 32'(1));
    end else begin
      repeat (DIV / 2) @(negedge clock);
      check("rx_start_mid", 32'(io_txd), 32'(0));
      for (int k = 0; k < 8; k++) begin
        repeat (DIV) @(negedge clock);
        b[k] = io_txd;
      end
      repeat (DIV) @(negedge clock);
      check("rx_stop_mid", 32'(io_txd), 32'(1));
    end
  endtask

  task automatic wait_idle(output int t);
    t = -1;
    for (int n = 0; n < 30 * DIV; n++) begin
      @(negedge clock);
      if (io_busy === 1'b0) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("idle_timeout", 32'(0), 32'(1));
  endtask

  logic [7:0] rb;
  logic [7:0] rxq [5];
  int         falls [5];
  int         acc, acc2, fall, tidle, lows;

  initial begin
    reset = 1'b0;
    v0 = 1'b1; b0 = 8'h00; l0 = 1'b0;
    v1 = 1'b0; b1 = 8'h00; l1 = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_txd", 32'(io_txd), 32'(1));
    check("rst_ready", 32'(bus.io_req_ready), 32'(0));
    check("rst_busy", 32'(io_busy), 32'(0));
    check("rst_gid", 32'(io_grant_id), 32'(0));
    @(negedge clock);
    v0    = 1'b0;
    reset = 1'b1;
    @(negedge clock);

    // Single byte 0x55 from requester 0.
    fork
      begin push(0, 8'h55, 1'b1, acc); v0 = 1'b0; end
      begin rx(rb, fall); check("t1_byte", 32'(rb), 32'h55); end
    join
    check("t1_latency", 32'(fall - acc), 32'(1));
    wait_idle(tidle);
    check("t1_frame_len", 32'(tidle - fall), 32'(FRAME));
    check("t1_gid", 32'(io_grant_id), 32'(0));

    // Requester 1 message "AB\n" locks out requester 0 holding 'X'.
    v0 = 1'b1; b0 = 8'h58; l0 = 1'b1;
    fork
      begin
        push(1, 8'h41, 1'b0, acc);
        check("t3_rdy0_after_a", 32'(bus.io_req_ready[0]), 32'(0));
        push(1, 8'h42, 1'b0, acc);
        check("t3_rdy0_after_b", 32'(bus.io_req_ready[0]), 32'(0));
        push(1, 8'h0a, 1'b1, acc);
        v1 = 1'b0;
        push(0, 8'h58, 1'b1, acc);
        v0 = 1'b0;
      end
      begin
        for (int k = 0; k < 4; k++) begin rx(rb, fall); rxq[k] = rb; end
      end
    join
    check("t3_b0", 32'(rxq[0]), 32'h41);
    check("t3_b1", 32'(rxq[1]), 32'h42);
    check("t3_b2", 32'(rxq[2]), 32'h0a);
    check("t3_b3", 32'(rxq[3]), 32'h58);
    wait_idle(tidle);

    // Lock timeout: owner 0 goes quiet after last=0, requester 1 waits.
    fork
      begin
        push(0, 8'h33, 1'b0, acc);
        v0 = 1'b0;
        check("t5_gid0", 32'(io_grant_id), 32'(0));
        push(1, 8'h44, 1'b1, acc2);
        v1 = 1'b0;
        check("t5_release", 32'(acc2 - acc), 32'(TO + 1));
        check("t5_gid1", 32'(io_grant_id), 32'(1));
      end
      begin
        for (int k = 0; k < 2; k++) begin rx(rb, fall); rxq[k] = rb; end
      end
    join
    check("t5_b0", 32'(rxq[0]), 32'h33);
    check("t5_b1", 32'(rxq[1]), 32'h44);
    wait_idle(tidle);

    // Simultaneous requests with pointer at 0.
    v1 = 1'b1; b1 = 8'h42; l1 = 1'b1;
    fork
      begin
        push(0, 8'h41, 1'b1, acc);
        v0 = 1'b0;
        check("t2_gid0", 32'(io_grant_id), 32'(0));
        push(1, 8'h42, 1'b1, acc);
        v1 = 1'b0;
        check("t2_gid1", 32'(io_grant_id), 32'(1));
      end
      begin
        for (int k = 0; k < 2; k++) begin rx(rb, fall); rxq[k] = rb; end
      end
    join
    check("t2_b0", 32'(rxq[0]), 32'h41);
    check("t2_b1", 32'(rxq[1]), 32'h42);
    wait_idle(tidle);

    // Four back-to-back bytes from requester 0 (pointer back at 0), then requester 1.
    v1 = 1'b1; b1 = 8'h77; l1 = 1'b1;
    fork
      begin
        push(0, 8'h10, 1'b0, acc);
        push(0, 8'h11, 1'b0, acc2);
        push(0, 8'h12, 1'b0, acc2);
        push(0, 8'h13, 1'b1, acc2);
        v0 = 1'b0;
        push(1, 8'h77, 1'b1, acc2);
        v1 = 1'b0;
      end
      begin
        for (int k = 0; k < 5; k++) begin rx(rb, fall); rxq[k] = rb; falls[k] = fall; end
      end
    join
    check("t4_b0", 32'(rxq[0]), 32'h10);
    check("t4_b1", 32'(rxq[1]), 32'h11);
    check("t4_b2", 32'(rxq[2]), 32'h12);
    check("t4_b3", 32'(rxq[3]), 32'h13);
    check("t4_b4", 32'(rxq[4]), 32'h77);
    check("t4_first_latency", 32'(falls[0] - acc), 32'(1));
    for (int k = 1; k < 4; k++) check("t4_gap", 32'(falls[k] - falls[k-1]), 32'(FRAME));
    check("t4_total", 32'(falls[4] - acc), 32'(4 * FRAME + 1));
    wait_idle(tidle);

    // Reset in the middle of data bit 2 of 0x5A from requester 1.
    push(1, 8'h5A, 1'b1, acc);
    v1 = 1'b0;
    fall = -1;
    for (int n = 0; n < 4 * DIV; n++) begin
      if (io_txd === 1'b0) begin fall = cyc; break; end
      @(negedge clock);
    end
    check("t6_latency", 32'(fall - acc), 32'(1));
    repeat (3 * DIV + DIV / 2) @(negedge clock);
    check("t6_bit2_before", 32'(io_txd), 32'(0));
    v0    = 1'b1;
    reset = 1'b0;
    #1;
    check("t6_rst_txd", 32'(io_txd), 32'(1));
    check("t6_rst_busy", 32'(io_busy), 32'(0));
    check("t6_rst_ready", 32'(bus.io_req_ready), 32'(0));
    check("t6_rst_gid", 32'(io_grant_id), 32'(0));
    v0 = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    lows  = 0;
    for (int n = 0; n < 2 * DIV; n++) begin
      @(negedge clock);
      if (io_txd !== 1'b1 || io_busy !== 1'b0) lows++;
    end
    check("t6_no_resume", 32'(lows), 32'(0));
    fork
      begin push(0, 8'hC3, 1'b1, acc); v0 = 1'b0; end
      begin rx(rb, fall); end
    join
    check("t6_new_byte", 32'(rb), 32'hC3);
    check("t6_new_latency", 32'(fall - acc), 32'(1));
    wait_idle(tidle);
    check("t6_new_frame_len", 32'(tidle - fall), 32'(FRAME));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
